// File: rtl/defuzz_centroid.sv
// Centroid defuzzifier: one MAC per cycle over N_SETS singletons, then a serial restoring divide.
// Optional output slew limiting is enabled by defining DEFUZZ_RATE_LIMIT_EN.
module defuzz_centroid #(
  parameter int unsigned N_SETS   = 11,
  parameter int unsigned MU_W     = 8,
  parameter int unsigned DUTY_W   = 8,
  parameter logic [N_SETS*DUTY_W-1:0] CENTERS = {8'd255, 8'd229, 8'd204, 8'd178, 8'd153, 8'd127,
                                                 8'd102, 8'd76, 8'd51, 8'd25, 8'd0},
  parameter int unsigned MAX_STEP = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N_SETS*MU_W-1:0]   mu_vec_i,
  output logic                     out_valid_o,
  output logic [DUTY_W-1:0]        pwm_duty_o,
  output logic                     zero_fire_o
);

  localparam int unsigned NUM_W = MU_W + DUTY_W + $clog2(N_SETS);
  localparam int unsigned DEN_W = MU_W + $clog2(N_SETS);
  localparam int unsigned CNT_W = $clog2(N_SETS + DUTY_W);

  typedef enum logic [1:0] {StIdle, StAccum, StDivide, StDone} state_e;

  state_e                   state_q, state_d;
  logic [N_SETS*MU_W-1:0]   mu_q, mu_d;
  logic [NUM_W-1:0]         num_q, num_d;
  logic [DEN_W-1:0]         den_q, den_d;
  logic [NUM_W-1:0]         div_q, div_d;
  logic [DUTY_W-1:0]        quo_q, quo_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [DUTY_W-1:0]        duty_q, duty_d;
  logic                     zero_q, zero_d;
  logic                     valid_q, valid_d;

  logic [MU_W-1:0]          mu_cur;
  logic [DUTY_W-1:0]        c_cur;
  logic [MU_W+DUTY_W-1:0]   prod;
  logic                     rem_ge;
  logic [DUTY_W-1:0]        next_duty;

  assign mu_cur = mu_q[idx_q*MU_W +: MU_W];
  assign c_cur  = CENTERS[idx_q*DUTY_W +: DUTY_W];
  assign prod   = mu_cur * c_cur;
  assign rem_ge = (num_q >= div_q);

`ifdef DEFUZZ_RATE_LIMIT_EN
  localparam logic signed [DUTY_W+1:0] MaxStepS = (DUTY_W+2)'(MAX_STEP);
  logic signed [DUTY_W+1:0] step;

  assign step = $signed({2'b00, quo_q}) - $signed({2'b00, duty_q});

  always_comb begin
    next_duty = quo_q;
    if (step > MaxStepS) begin
      next_duty = duty_q + DUTY_W'(MAX_STEP);
    end else if (step < -MaxStepS) begin
      next_duty = duty_q - DUTY_W'(MAX_STEP);
    end
  end
`else
  // MAX_STEP only matters when slew limiting is built in.
  logic unused_max_step;
  assign unused_max_step = ^MAX_STEP;
  assign next_duty       = quo_q;
`endif

  always_comb begin
    state_d    = state_q;
    mu_d       = mu_q;
    num_d      = num_q;
    den_d      = den_q;
    div_d      = div_q;
    quo_d      = quo_q;
    idx_d      = idx_q;
    duty_d     = duty_q;
    zero_d     = zero_q;
    valid_d    = 1'b0;
    in_ready_o = (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          mu_d    = mu_vec_i;
          num_d   = '0;
          den_d   = '0;
          idx_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        num_d = num_q + NUM_W'(prod);
        den_d = den_q + DEN_W'(mu_cur);
        idx_d = idx_q + 1'b1;
        if (idx_q == CNT_W'(N_SETS - 1)) begin
          idx_d = '0;
          // Divisor pre-aligned to the quotient MSB; shifted right once per step.
          div_d   = NUM_W'(den_d) << (DUTY_W - 1);
          state_d = (den_d == '0) ? StDone : StDivide;
        end
      end
      StDivide: begin
        if (rem_ge) begin
          num_d = num_q - div_q;
        end
        quo_d = {quo_q[DUTY_W-2:0], rem_ge};
        div_d = div_q >> 1;
        idx_d = idx_q + 1'b1;
        if (idx_q == CNT_W'(DUTY_W - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        valid_d = 1'b1;
        state_d = StIdle;
        if (den_q == '0) begin
          zero_d = 1'b1;
        end else begin
          zero_d = 1'b0;
          duty_d = next_duty;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mu_q    <= '0;
      num_q   <= '0;
      den_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      idx_q   <= '0;
      duty_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mu_q    <= mu_d;
      num_q   <= num_d;
      den_q   <= den_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      idx_q   <= idx_d;
      duty_q  <= duty_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid_o = valid_q;
  assign pwm_duty_o  = duty_q;
  assign zero_fire_o = zero_q;

endmodule

// File: tb/tb_defuzz_centroid.sv
// Directed bench for defuzz_centroid with default parameters; the slew-limit sequence
// runs instead of the vector table when DEFUZZ_RATE_LIMIT_EN is defined.
module tb_defuzz_centroid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [87:0] mu_vec;
  logic        out_valid;
  logic [7:0]  pwm_duty;
  logic        zero_fire;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int base;
    int ia;
    int ma;
    int ib;
    int mb;
    int duty;
    int zero;
    int lat;
  } vec_t;

  defuzz_centroid dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mu_vec_i    (mu_vec),
    .out_valid_o (out_valid),
    .pwm_duty_o  (pwm_duty),
    .zero_fire_o (zero_fire)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [87:0] build(input int base, input int ia, input int ma,
                                        input int ib, input int mb);
    logic [87:0] v;
    for (int i = 0; i < 11; i++) v[i*8 +: 8] = base[7:0];
    v[ia*8 +: 8] = ma[7:0];
    v[ib*8 +: 8] = mb[7:0];
    return v;
  endfunction

  // in_valid stays high and mu_vec is scrambled while busy: neither may disturb the result.
  task automatic run_vec(input logic [87:0] v, input int e_duty, input int e_zero,
                         input int e_lat, input string tag);
    int          lat;
    int          busy_ok;
    logic [95:0] junk;
    check({tag, " ready_before"}, int'(in_ready), 1);
    mu_vec   = v;
    in_valid = 1'b1;
    tick();
    lat     = 0;
    busy_ok = 1;
    while (lat < 40) begin
      junk   = {$urandom(), $urandom(), $urandom()};
      mu_vec = junk[87:0];
      tick();
      lat++;
      if (out_valid) break;
      if (in_ready) busy_ok = 0;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, lat, e_lat);
    check({tag, " ready_low_busy"}, busy_ok, 1);
    check({tag, " duty"}, int'(pwm_duty), e_duty);
    check({tag, " zero_fire"}, int'(zero_fire), e_zero);
    check({tag, " ready_at_done"}, int'(in_ready), 1);
    tick();
    check({tag, " single_pulse"}, int'(out_valid), 0);
  endtask

  initial begin
    vec_t vt[12];
    int   pulses;

    vt[0]  = '{0, 0, 0,   0,  0,   0,   1, 12};
    vt[1]  = '{0, 5, 255, 5,  255, 127, 0, 20};
    vt[2]  = '{0, 0, 100, 10, 100, 127, 0, 20};
    vt[3]  = '{0, 2, 200, 3,  100, 59,  0, 20};
    vt[4]  = '{0, 10, 255, 10, 255, 255, 0, 20};
    vt[5]  = '{0, 0, 0,   0,  0,   255, 1, 12};
    vt[6]  = '{0, 1, 1,   1,  1,   25,  0, 20};
    vt[7]  = '{0, 0, 255, 1,  1,   0,   0, 20};
    vt[8]  = '{0, 9, 3,   10, 1,   235, 0, 20};
    vt[9]  = '{0, 4, 7,   6,  5,   123, 0, 20};
    vt[10] = '{255, 0, 255, 0, 255, 127, 0, 20};
    vt[11] = '{1, 10, 255, 10, 255, 249, 0, 20};

    rst      = 1'b1;
    in_valid = 1'b0;
    mu_vec   = '0;
    tick();
    tick();
    check("reset in_ready", int'(in_ready), 1);
    check("reset out_valid", int'(out_valid), 0);
    check("reset pwm_duty", int'(pwm_duty), 0);
    check("reset zero_fire", int'(zero_fire), 0);
    rst = 1'b0;
    tick();

`ifdef DEFUZZ_RATE_LIMIT_EN
    run_vec(build(0, 0, 0, 0, 0), 0, 1, 12, "rl_zero");
    run_vec(build(0, 10, 255, 10, 255), 16, 0, 20, "rl_step1");
    run_vec(build(0, 10, 255, 10, 255), 32, 0, 20, "rl_step2");
    run_vec(build(0, 10, 255, 10, 255), 48, 0, 20, "rl_step3");
`else
    for (int i = 0; i < 12; i++) begin
      run_vec(build(vt[i].base, vt[i].ia, vt[i].ma, vt[i].ib, vt[i].mb),
              vt[i].duty, vt[i].zero, vt[i].lat, $sformatf("vec%0d", i));
    end
`endif

    // Reset while dividing: result dropped, duty cleared, no late pulse.
    mu_vec   = build(0, 5, 255, 5, 255);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_div out_valid", int'(out_valid), 0);
    check("rst_div pwm_duty", int'(pwm_duty), 0);
    check("rst_div in_ready", int'(in_ready), 1);
    check("rst_div zero_fire", int'(zero_fire), 0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("rst_div late_pulse", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
